// File: rtl/seg_pkg.sv
// Shared types and the hex-to-7-segment table for display blocks.
// Segment encoding is active-low {g,f,e,d,c,b,a}.
package seg_pkg;

   typedef logic [6:0] seg7_t;

   localparam seg7_t SEG_OFF = 7'h7F;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } scan_state_t;

   // Active-low glyphs for 0-9, A, b, C, d, E, F.
   function automatic seg7_t seg_decode(input logic [3:0] hex);
      seg7_t s;
      case (hex)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display bus between the hex display peripheral / board pins and the scanner.
//   number_i : 4 bits per digit, digit 0 in the low nibble
//   blank_i  : per-digit dark control
//   dp_i     : per-digit decimal point
//   an_o     : active-low anodes
//   seg_o    : active-low cathodes {g,f,e,d,c,b,a}
//   dp_o     : active-low decimal-point cathode
//   frame_o  : one-cycle pulse at scan wrap to digit 0
// master = source of the number word, slave = the scanner.
interface seg_scan_ctrl_if import seg_pkg::*; #(
   parameter int NUM_DIGITS = 4
) ();
   logic [4*NUM_DIGITS-1:0] number_i;
   logic [NUM_DIGITS-1:0]   blank_i;
   logic [NUM_DIGITS-1:0]   dp_i;
   logic [NUM_DIGITS-1:0]   an_o;
   seg7_t                   seg_o;
   logic                    dp_o;
   logic                    frame_o;

   modport master (output number_i, blank_i, dp_i,
                   input  an_o, seg_o, dp_o, frame_o);
   modport slave  (input  number_i, blank_i, dp_i,
                   output an_o, seg_o, dp_o, frame_o);
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment glyph.
//   hex : 4-bit value
//   seg : active-low {g,f,e,d,c,b,a}
module hex_to_seg7 import seg_pkg::*; (
   input  logic [3:0] hex,
   output seg7_t      seg
);
   assign seg = seg_decode(hex);
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scanner with per-slot dead time.
// Each slot is DIGIT_CYCLES long; the first BLANK_CYCLES keep all anodes off,
// then the current digit is snapshotted and held until the slot ends.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset, forces pins dark
//   bus    : display bus (slave side), see seg_scan_ctrl_if
module seg_scan_ctrl import seg_pkg::*; #(
   parameter int NUM_DIGITS   = 4,
   parameter int DIGIT_CYCLES = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   seg_scan_ctrl_if.slave  bus
);
   localparam int CW = $clog2(DIGIT_CYCLES);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(DIGIT_CYCLES - 1);
   // Count value one edge before DRIVE entry; unused when there is no dead time.
   localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;

   logic [CW-1:0]         cnt;
   logic [IW-1:0]         idx, idx_nxt, sel;
   scan_state_t           state;
   logic                  last, load_drive, sel_blank, sel_dp;
   logic [3:0]            nib;
   seg7_t                 glyph;
   logic [NUM_DIGITS-1:0] an_q;
   seg7_t                 seg_q;
   logic                  dp_q, frame_q;

   always_comb begin
      last    = (cnt == CNT_LAST);
      idx_nxt = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      // With zero dead time the wrap edge already loads the next digit.
      sel     = last ? idx_nxt : idx;
      nib       = bus.number_i[4*sel +: 4];
      sel_blank = bus.blank_i[sel];
      sel_dp    = bus.dp_i[sel];
      if (last)
         load_drive = (BLANK_CYCLES == 0);
      else
         load_drive = (BLANK_CYCLES > 0) && (cnt == BLANK_LAST) && (state == ST_BLANK);
   end

   hex_to_seg7 u_dec (.hex(nib), .seg(glyph));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt     <= '0;
         idx     <= '0;
         state   <= ST_BLANK;
         an_q    <= '1;
         seg_q   <= SEG_OFF;
         dp_q    <= 1'b1;
         frame_q <= 1'b0;
      end else begin
         frame_q <= last && (idx == IW'(NUM_DIGITS - 1));
         cnt     <= last ? '0 : cnt + 1'b1;
         if (last) idx <= idx_nxt;
         if (load_drive) begin
            state <= ST_DRIVE;
            an_q  <= ~(NUM_DIGITS'(1) << sel);
            seg_q <= sel_blank ? SEG_OFF : glyph;
            dp_q  <= ~(sel_dp & ~sel_blank);
         end else if (last) begin
            state <= ST_BLANK;
            an_q  <= '1;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
         end
      end
   end

   assign bus.an_o    = an_q;
   assign bus.seg_o   = seg_q;
   assign bus.dp_o    = dp_q;
   assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench: two scanners (8-cycle slots, dead time 2 and 0) share clock,
// reset and inputs; expected values come from hand tables.
module tb_seg_scan_ctrl;
   import seg_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seg_scan_ctrl_if #(.NUM_DIGITS(4)) ba ();
   seg_scan_ctrl_if #(.NUM_DIGITS(4)) bz ();

   seg_scan_ctrl #(.NUM_DIGITS(4), .DIGIT_CYCLES(8), .BLANK_CYCLES(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .bus(ba.slave));
   seg_scan_ctrl #(.NUM_DIGITS(4), .DIGIT_CYCLES(8), .BLANK_CYCLES(0)) dut_z (
      .clk_i(clk), .rst_ni(rst_n), .bus(bz.slave));

   int checks = 0;
   int failures = 0;
   int ecnt = 0;
   int ovl_err = 0;
   int chg_err = 0;

   logic [3:0] an_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
   logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   // digits of 16'h1234 in scan order 0..3
   logic [6:0] scan_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, ecnt);
      end
   endtask

   task automatic set_in(input logic [15:0] num, input logic [3:0] blk, input logic [3:0] dp);
      ba.number_i = num; ba.blank_i = blk; ba.dp_i = dp;
      bz.number_i = num; bz.blank_i = blk; bz.dp_i = dp;
   endtask

   task automatic adv();
      @(posedge clk);
      @(negedge clk);
      ecnt++;
   endtask

   task automatic goto(input int m);
      while (ecnt % 32 != m) adv();
   endtask

   // Invariants: never two anodes low; seg only changes across a dark frame.
   logic [3:0] prev_an = 4'hF;
   logic [6:0] prev_seg = 7'h7F;
   always @(negedge clk) begin
      if (rst_n) begin
         if ($countones(~ba.an_o) > 1 || $countones(~bz.an_o) > 1) ovl_err++;
         if (ba.seg_o != prev_seg && ba.an_o != 4'hF && prev_an != 4'hF) chg_err++;
         if (ecnt >= 8 && bz.an_o == 4'hF) ovl_err++;
      end
      prev_an  = ba.an_o;
      prev_seg = ba.seg_o;
   end

   initial begin
      int cn, ix;
      logic [3:0] nb;
      set_in(16'h0000, 4'h0, 4'h0);
      repeat (3) @(negedge clk);
      chk("rst_an", ba.an_o, 4'hF);
      chk("rst_seg", ba.seg_o, 7'h7F);
      chk("rst_dp", ba.dp_o, 1'b1);
      chk("rst_frame", ba.frame_o, 1'b0);
      #2 rst_n = 1'b1;
      #1;
      chk("rel_an", ba.an_o, 4'hF);
      chk("rel_seg", ba.seg_o, 7'h7F);
      chk("rel_z_an", bz.an_o, 4'hF);
      set_in(16'h1234, 4'h0, 4'h0);

      // scan of 16'h1234 over slightly more than one frame
      for (int i = 1; i <= 40; i++) begin
         adv();
         cn = ecnt % 8;
         ix = (ecnt / 8) % 4;
         chk("scan_an", ba.an_o, (cn < 2) ? 4'hF : an_tab[ix]);
         chk("scan_seg", ba.seg_o, (cn < 2) ? 7'h7F : scan_seg[ix]);
         chk("scan_dp", ba.dp_o, 1'b1);
         chk("frame", ba.frame_o, (ecnt % 32 == 0) ? 1'b1 : 1'b0);
         chk("z_frame", bz.frame_o, (ecnt % 32 == 0) ? 1'b1 : 1'b0);
         if (ecnt >= 8) begin
            chk("z_an", bz.an_o, an_tab[ix]);
            chk("z_seg", bz.seg_o, scan_seg[ix]);
         end else
            chk("z_first_dark", bz.an_o, 4'hF);
      end

      // decode sweep on digit 0
      for (int n = 0; n < 16; n++) begin
         goto(1);
         nb = n[3:0];
         set_in({12'h123, nb}, 4'h0, 4'h0);
         adv();
         chk("dec_an", ba.an_o, 4'hE);
         chk("dec_seg", ba.seg_o, dec_tab[n]);
      end

      // blank digit 0
      goto(1);
      set_in(16'h1238, 4'h1, 4'h0);
      adv();
      chk("blank_an", ba.an_o, 4'hE);
      chk("blank_seg", ba.seg_o, 7'h7F);
      chk("blank_dp", ba.dp_o, 1'b1);

      // decimal point on digit 0 only
      goto(1);
      set_in(16'h1238, 4'h0, 4'h1);
      adv();
      chk("dp_d0", ba.dp_o, 1'b0);
      goto(8);
      chk("dp_dark", ba.dp_o, 1'b1);
      goto(10);
      chk("dp_d1", ba.dp_o, 1'b1);

      // no tearing: switch word mid-slot of digit 1
      goto(8);
      set_in(16'h0000, 4'h0, 4'h0);
      goto(13);
      chk("tear_pre", ba.seg_o, 7'h40);
      set_in(16'hFFFF, 4'h0, 4'h0);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) adv();
         chk("tear_hold", ba.seg_o, 7'h40);
         chk("tear_an", ba.an_o, 4'hD);
      end
      goto(18);
      chk("tear_next_seg", ba.seg_o, 7'h0E);
      chk("tear_next_an", ba.an_o, 4'hB);

      // reset mid-slot darkens pins without a clock edge
      goto(20);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_an", ba.an_o, 4'hF);
      chk("mid_rst_seg", ba.seg_o, 7'h7F);
      chk("mid_rst_dp", ba.dp_o, 1'b1);
      chk("mid_rst_z_an", bz.an_o, 4'hF);
      chk("mid_rst_z_seg", bz.seg_o, 7'h7F);

      chk("onehot_inv", ovl_err, 0);
      chk("seg_change_inv", chg_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed 4-digit 7-segment scanner. It sits directly downstream of the hex display peripheral and consumes its 16-bit displayed-number word plus per-digit blank and decimal-point controls. It drives active-low anode and cathode pins on the board. It inserts a programmable dead time between digits to suppress ghosting, and snapshots each digit's value at slot start so mid-slot updates never tear.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (anodes)
DIGIT_CYCLES, 100000, clock cycles per digit slot (1 ms at 100 MHz); must be >= 2 and > BLANK_CYCLES
BLANK_CYCLES, 1000, dead-time cycles at the start of each slot with all anodes off; 0 allowed (no dead time)

Ports:
clk_i  input  1  system clock (100 MHz)
rst_ni  input  1  asynchronous reset, active-low
number_i  input  4*NUM_DIGITS  hex nibbles; digit k = number_i[4k+3:4k], digit 0 rightmost
blank_i  input  NUM_DIGITS  1 = digit k dark (segments off, anode still scanned off)
dp_i  input  NUM_DIGITS  1 = decimal point of digit k lit
an_o  output  NUM_DIGITS  anodes, active-low, one-hot-low or all ones
seg_o  output  7  cathodes {g,f,e,d,c,b,a}, active-low
dp_o  output  1  decimal-point cathode, active-low
frame_o  output  1  one-cycle pulse when scan wraps from last digit to digit 0

Behaviour:
- Reset (rst_ni=0, async): an_o='1, seg_o=7'h7F, dp_o=1, frame_o=0, slot counter cnt=0, digit index idx=0, state BLANK. Release resumes at cnt=0, idx=0.
- cnt counts 0..DIGIT_CYCLES-1 and wraps to 0. On wrap, idx increments and goes from NUM_DIGITS-1 to 0.
- State BLANK while cnt < BLANK_CYCLES: an_o='1, seg_o=7'h7F, dp_o=1.
- State DRIVE while cnt >= BLANK_CYCLES.
- Entering DRIVE: on the edge where cnt becomes BLANK_CYCLES, sample number_i/blank_i/dp_i for digit idx. On that same edge register an_o = ~(1<<idx), seg_o = blank ? 7'h7F : decode(nibble), dp_o = ~(dp & ~blank).
- Outputs are held constant for the rest of the slot. Input changes during a slot take effect at the next slot's DRIVE entry.
- Exit from DRIVE: on the edge where cnt wraps to 0, outputs return to BLANK values.
- BLANK_CYCLES=0: the wrap edge loads the next digit's DRIVE values directly. Anodes are never all-off between slots.
- frame_o=1 for exactly the one cycle following the edge where idx goes NUM_DIGITS-1 -> 0. Period = NUM_DIGITS*DIGIT_CYCLES.
- Decode (active-low, gfedcba): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E (hex).
- All outputs are registered, with no combinational path from inputs to pins. At most one an_o bit is low at any time.
- Counter widths: cnt uses $clog2(DIGIT_CYCLES) bits; idx uses $clog2(NUM_DIGITS) bits (min 1). idx must never reach NUM_DIGITS.
- Reset asserted mid-slot forces pins dark immediately, with no clock required.

Decomposition:
- Package seg_pkg holds: SEG_OFF=7'h7F; the function or constant array for the hex-to-7seg decode table; the typedef seg7_t (logic [6:0]).
- One combinational sub-module, hex_to_seg7 (4-bit in, seg7_t out), wraps the table and is reusable by other display blocks.
- Scan FSM, counters and output registers live in seg_scan_ctrl.

Test Plan:
All scenarios run with NUM_DIGITS=4, DIGIT_CYCLES=8, BLANK_CYCLES=2.
- Reset: hold rst_ni=0, toggle clk. Then deassert rst_ni asynchronously mid-slot -> immediately an_o=4'hF, seg_o=7'h7F, dp_o=1, frame_o=0. First DRIVE occurs 2 cycles after release.
- Scan: number_i=16'h1234, blank_i=0, dp_i=0 -> per 8-cycle slot, 2 cycles dark then 6 cycles of:
  - an_o=E, seg_o=19 (digit 4)
  - an_o=D, seg_o=30
  - an_o=B, seg_o=24
  - an_o=7, seg_o=79
  Then frame_o pulses once every 32 cycles.
- Decode sweep: drive all 16 nibbles on digit 0 -> seg_o matches the table (e.g. A->08, F->0E). blank_i[0]=1 gives 7F. dp_i[0]=1 gives dp_o=0 only during digit 0 DRIVE.
- No tearing: change number_i from 16'h0000 to 16'hFFFF at cnt=5 of the digit-1 slot -> seg_o stays 40 until that slot ends. Digit 2 shows 0E.
- Zero dead time: BLANK_CYCLES=0 -> an_o never 4'hF after the first slot. Check the an_o one-hot-low invariant on every cycle.
- Overlap check (all configurations): assertion that $countones(~an_o)<=1 at all times, and that an_o='1 whenever seg_o changes between digits.
